// File: rtl/wms_pkg.sv
// Shared types and widths for the weight memory server.
package wms_pkg;

  localparam int unsigned LINE_W         = 512;
  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned WORD_W         = 64;
  localparam int unsigned PERF_W         = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  typedef enum logic {
    REQ_RDN = 1'b0,
    REQ_DNN = 1'b1
  } req_t;

  // One cache line viewed as eight 64-bit words, word i at bits 64i+63:64i.
  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

  function automatic req_t other_req(input req_t r);
    return (r == REQ_RDN) ? REQ_DNN : REQ_RDN;
  endfunction

endpackage

// File: rtl/wms_line_ctr.sv
// Per-network line cursor: latched base/count, current line address, wrap and sticky done.
module wms_line_ctr #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_lines,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr_c,
  output logic              configured_c,
  output logic              done
);

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  idx_q;
  logic              last_c;

  assign configured_c = (num_q != '0);
  assign last_c       = (idx_q == (num_q - CNT_W'(1)));
  assign addr_c       = base_q + ADDR_W'(idx_q);

  // Index wraps to zero after the final line and marks the pass complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      num_q  <= '0;
      idx_q  <= '0;
      done   <= 1'b0;
    end else if (load) begin
      base_q <= base_addr;
      num_q  <= num_lines;
      idx_q  <= '0;
      done   <= 1'b0;
    end else if (advance && configured_c) begin
      if (last_c) begin
        idx_q <= '0;
        done  <= 1'b1;
      end else begin
        idx_q <= idx_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/weight_mem_server.sv
// Arbitrates RDN/DNN weight-line requests onto a single-outstanding host read port.
// Optional wait-cycle counters are enabled with `define WMS_PERF_CNT_EN.
module weight_mem_server
  import wms_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] rdn_base_addr,
  input  logic [ADDR_W-1:0] dnn_base_addr,
  input  logic [CNT_W-1:0]  rdn_num_lines,
  input  logic [CNT_W-1:0]  dnn_num_lines,
  input  logic              rdn_mem_req,
  input  logic              dnn_mem_req,
  output logic              weight_mem_ready,
  output logic              weight_mem_sel,
  output line_t             rdn_weight_data,
  output line_t             dnn_weight_data,
  output logic              rd_req_vld,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_req_rdy,
  input  logic              rd_rsp_vld,
  input  logic [LINE_W-1:0] rd_rsp_data,
  output logic              rdn_done,
  output logic              dnn_done,
  output logic              busy
`ifdef WMS_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_rdn_wait,
  output logic [PERF_W-1:0] perf_dnn_wait
`endif
);

  state_t            state;
  req_t              grant;
  req_t              rr_ptr;
  req_t              next_grant_c;
  logic              load_c;
  logic              adv_rdn_c;
  logic              adv_dnn_c;
  logic              pend_rdn_c;
  logic              pend_dnn_c;
  logic              rdn_cfg_c;
  logic              dnn_cfg_c;
  logic [ADDR_W-1:0] rdn_addr_c;
  logic [ADDR_W-1:0] dnn_addr_c;

  assign load_c     = start && (state == IDLE);
  assign adv_rdn_c  = (state == DELIVER) && (grant == REQ_RDN);
  assign adv_dnn_c  = (state == DELIVER) && (grant == REQ_DNN);
  assign pend_rdn_c = rdn_mem_req && rdn_cfg_c;
  assign pend_dnn_c = dnn_mem_req && dnn_cfg_c;

  wms_line_ctr #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_rdn_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load_c),
    .base_addr    (rdn_base_addr),
    .num_lines    (rdn_num_lines),
    .advance      (adv_rdn_c),
    .addr_c       (rdn_addr_c),
    .configured_c (rdn_cfg_c),
    .done         (rdn_done)
  );

  wms_line_ctr #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dnn_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load_c),
    .base_addr    (dnn_base_addr),
    .num_lines    (dnn_num_lines),
    .advance      (adv_dnn_c),
    .addr_c       (dnn_addr_c),
    .configured_c (dnn_cfg_c),
    .done         (dnn_done)
  );

  // Round-robin only matters under contention; a lone request always wins.
  always_comb begin
    next_grant_c = REQ_RDN;
    if (pend_rdn_c && pend_dnn_c) begin
      next_grant_c = rr_ptr;
    end else if (pend_dnn_c) begin
      next_grant_c = REQ_DNN;
    end
  end

  // Request/response sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      grant            <= REQ_RDN;
      rr_ptr           <= REQ_RDN;
      rd_req_vld       <= 1'b0;
      rd_req_addr      <= '0;
      weight_mem_ready <= 1'b0;
      weight_mem_sel   <= 1'b0;
      rdn_weight_data  <= '0;
      dnn_weight_data  <= '0;
      busy             <= 1'b0;
    end else begin
      weight_mem_ready <= 1'b0;
      weight_mem_sel   <= 1'b0;
      case (state)
        IDLE: begin
          if (!start && (pend_rdn_c || pend_dnn_c)) begin
            grant       <= next_grant_c;
            rr_ptr      <= other_req(next_grant_c);
            rd_req_vld  <= 1'b1;
            rd_req_addr <= (next_grant_c == REQ_DNN) ? dnn_addr_c : rdn_addr_c;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (rd_req_rdy) begin
            rd_req_vld <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (rd_rsp_vld) begin
            if (grant == REQ_DNN) begin
              dnn_weight_data <= line_t'(rd_rsp_data);
            end else begin
              rdn_weight_data <= line_t'(rd_rsp_data);
            end
            weight_mem_ready <= 1'b1;
            weight_mem_sel   <= grant;
            state            <= DELIVER;
          end
        end
        DELIVER: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rd_req_vld <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef WMS_PERF_CNT_EN
  logic strobe_rdn_c;
  logic strobe_dnn_c;

  assign strobe_rdn_c = weight_mem_ready && !weight_mem_sel;
  assign strobe_dnn_c = weight_mem_ready && weight_mem_sel;

  // Saturating count of cycles each requester spends waiting for its line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rdn_wait <= '0;
      perf_dnn_wait <= '0;
    end else if (load_c) begin
      perf_rdn_wait <= '0;
      perf_dnn_wait <= '0;
    end else begin
      if (rdn_mem_req && !strobe_rdn_c && (perf_rdn_wait != '1)) begin
        perf_rdn_wait <= perf_rdn_wait + PERF_W'(1);
      end
      if (dnn_mem_req && !strobe_dnn_c && (perf_dnn_wait != '1)) begin
        perf_dnn_wait <= perf_dnn_wait + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_weight_mem_server.sv
// Directed self-checking bench for weight_mem_server (covers WMS_PERF_CNT_EN when defined).
module tb_weight_mem_server;
  import wms_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] rdn_base_addr;
  logic [ADDR_W-1:0] dnn_base_addr;
  logic [CNT_W-1:0]  rdn_num_lines;
  logic [CNT_W-1:0]  dnn_num_lines;
  logic              rdn_mem_req;
  logic              dnn_mem_req;
  logic              weight_mem_ready;
  logic              weight_mem_sel;
  line_t             rdn_weight_data;
  line_t             dnn_weight_data;
  logic              rd_req_vld;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_req_rdy;
  logic              rd_rsp_vld;
  logic [LINE_W-1:0] rd_rsp_data;
  logic              rdn_done;
  logic              dnn_done;
  logic              busy;
`ifdef WMS_PERF_CNT_EN
  logic [PERF_W-1:0] perf_rdn_wait;
  logic [PERF_W-1:0] perf_dnn_wait;
`endif

  int errors = 0;
  int checks = 0;

  weight_mem_server #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .rdn_base_addr    (rdn_base_addr),
    .dnn_base_addr    (dnn_base_addr),
    .rdn_num_lines    (rdn_num_lines),
    .dnn_num_lines    (dnn_num_lines),
    .rdn_mem_req      (rdn_mem_req),
    .dnn_mem_req      (dnn_mem_req),
    .weight_mem_ready (weight_mem_ready),
    .weight_mem_sel   (weight_mem_sel),
    .rdn_weight_data  (rdn_weight_data),
    .dnn_weight_data  (dnn_weight_data),
    .rd_req_vld       (rd_req_vld),
    .rd_req_addr      (rd_req_addr),
    .rd_req_rdy       (rd_req_rdy),
    .rd_rsp_vld       (rd_rsp_vld),
    .rd_rsp_data      (rd_rsp_data),
    .rdn_done         (rdn_done),
    .dnn_done         (dnn_done),
    .busy             (busy)
`ifdef WMS_PERF_CNT_EN
    ,
    .perf_rdn_wait    (perf_rdn_wait),
    .perf_dnn_wait    (perf_dnn_wait)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic line_t mk_line(input logic [WORD_W-1:0] b);
    line_t l;
    for (int i = 0; i < int'(WORDS_PER_LINE); i++) l[i] = b + WORD_W'(i);
    return l;
  endfunction

  task automatic do_start(input logic [ADDR_W-1:0] rb, input logic [CNT_W-1:0] rn,
                          input logic [ADDR_W-1:0] db, input logic [CNT_W-1:0] dn);
    rdn_base_addr = rb;
    rdn_num_lines = rn;
    dnn_base_addr = db;
    dnn_num_lines = dn;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_vld(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd_req_vld) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Serve one line: see the read, stall, respond after lat cycles, land in the strobe cycle.
  task automatic fetch(input string tag, input logic [ADDR_W-1:0] exp_addr, input logic exp_sel,
                       input int stall, input int lat, input line_t data);
    bit ok;
    wait_vld(ok);
    check({tag, "_vld"}, LINE_W'(ok), LINE_W'(1));
    check({tag, "_addr"}, LINE_W'(rd_req_addr), LINE_W'(exp_addr));
    for (int i = 0; i < stall; i++) begin
      rd_req_rdy = 1'b0;
      tick();
      check({tag, "_stall_vld"}, LINE_W'(rd_req_vld), LINE_W'(1));
      check({tag, "_stall_addr"}, LINE_W'(rd_req_addr), LINE_W'(exp_addr));
      check({tag, "_stall_nostrobe"}, LINE_W'(weight_mem_ready), LINE_W'(0));
    end
    rd_req_rdy = 1'b1;
    tick();
    rd_req_rdy = 1'b0;
    check({tag, "_vld_drop"}, LINE_W'(rd_req_vld), LINE_W'(0));
    for (int i = 1; i < lat; i++) begin
      check({tag, "_wait_nostrobe"}, LINE_W'(weight_mem_ready), LINE_W'(0));
      tick();
    end
    rd_rsp_vld  = 1'b1;
    rd_rsp_data = data;
    tick();
    rd_rsp_vld  = 1'b0;
    check({tag, "_ready"}, LINE_W'(weight_mem_ready), LINE_W'(1));
    check({tag, "_sel"}, LINE_W'(weight_mem_sel), LINE_W'(exp_sel));
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0;
    rdn_base_addr = '0; dnn_base_addr = '0; rdn_num_lines = '0; dnn_num_lines = '0;
    rdn_mem_req = 1'b0; dnn_mem_req = 1'b0;
    rd_req_rdy = 1'b0; rd_rsp_vld = 1'b0; rd_rsp_data = '0;
    tick(); tick();

    // reset state
    check("rst_ready", LINE_W'(weight_mem_ready), LINE_W'(0));
    check("rst_vld", LINE_W'(rd_req_vld), LINE_W'(0));
    check("rst_addr", LINE_W'(rd_req_addr), LINE_W'(0));
    check("rst_busy", LINE_W'(busy), LINE_W'(0));
    check("rst_rdn_bus", rdn_weight_data, '0);
    check("rst_dnn_bus", dnn_weight_data, '0);
    check("rst_done", LINE_W'({rdn_done, dnn_done}), LINE_W'(0));
    rst_n = 1'b1;
    tick();

    // single RDN with wrap
    do_start(32'h100, 16'd3, 32'h0, 16'd0);
    rdn_mem_req = 1'b1;
    fetch("rdn0", 32'h100, 1'b0, 0, 1, mk_line(64'hA0));
    for (int i = 0; i < 8; i++) begin
      logic [WORD_W-1:0] w;
      w = rdn_weight_data[i];
      check("pack_word", LINE_W'(w), LINE_W'(64'hA0 + 64'(i)));
    end
    check("pack_dnn_hold", dnn_weight_data, '0);
    check("rdn0_done", LINE_W'(rdn_done), LINE_W'(0));
    fetch("rdn1", 32'h101, 1'b0, 0, 1, mk_line(64'h10));
    fetch("rdn2", 32'h102, 1'b0, 0, 1, mk_line(64'h20));
    tick();
    check("rdn_done_set", LINE_W'(rdn_done), LINE_W'(1));
    check("idle_busy", LINE_W'(busy), LINE_W'(0));
    fetch("rdn3", 32'h100, 1'b0, 0, 1, mk_line(64'h30));
    check("rdn3_data", rdn_weight_data, mk_line(64'h30));
    rdn_mem_req = 1'b0;
    tick();

    // contention after reset: RDN, DNN, RDN, DNN
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    do_start(32'h200, 16'd4, 32'h300, 16'd2);
    rdn_mem_req = 1'b1; dnn_mem_req = 1'b1;
    fetch("ct0", 32'h200, 1'b0, 0, 1, mk_line(64'hB0));
    check("ct0_rdn", rdn_weight_data, mk_line(64'hB0));
    check("ct0_dnn", dnn_weight_data, '0);
    fetch("ct1", 32'h300, 1'b1, 0, 2, mk_line(64'hC0));
    check("ct1_rdn", rdn_weight_data, mk_line(64'hB0));
    check("ct1_dnn", dnn_weight_data, mk_line(64'hC0));
    fetch("ct2", 32'h201, 1'b0, 0, 1, mk_line(64'hD0));
    check("ct2_rdn", rdn_weight_data, mk_line(64'hD0));
    check("ct2_dnn", dnn_weight_data, mk_line(64'hC0));
    fetch("ct3", 32'h301, 1'b1, 0, 1, mk_line(64'hE0));
    check("ct3_dnn", dnn_weight_data, mk_line(64'hE0));
    rdn_mem_req = 1'b0; dnn_mem_req = 1'b0;
    tick();
    check("ct_dnn_done", LINE_W'(dnn_done), LINE_W'(1));
    check("ct_rdn_done", LINE_W'(rdn_done), LINE_W'(0));

    // backpressure: 5 stalled cycles, slow memory
    rdn_mem_req = 1'b1;
    fetch("bp", 32'h202, 1'b0, 5, 3, mk_line(64'hF0));
    check("bp_data", rdn_weight_data, mk_line(64'hF0));
    rdn_mem_req = 1'b0;
    tick();

    // unconfigured DNN and stray response in IDLE
    do_start(32'h400, 16'd2, 32'h900, 16'd0);
    dnn_mem_req = 1'b1;
    rd_rsp_vld = 1'b1; rd_rsp_data = mk_line(64'h55);
    tick();
    rd_rsp_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("uncfg_busy", LINE_W'(busy), LINE_W'(0));
      check("uncfg_vld", LINE_W'(rd_req_vld), LINE_W'(0));
      check("uncfg_ready", LINE_W'(weight_mem_ready), LINE_W'(0));
      tick();
    end
    check("stray_rdn", rdn_weight_data, mk_line(64'hF0));
    check("stray_dnn", dnn_weight_data, mk_line(64'hE0));

    // reset while waiting for a response
    rdn_mem_req = 1'b1;
    wait_vld(ok);
    check("rw_vld", LINE_W'(ok), LINE_W'(1));
    check("rw_addr", LINE_W'(rd_req_addr), LINE_W'(32'h400));
    rd_req_rdy = 1'b1; tick(); rd_req_rdy = 1'b0;
    check("rw_busy", LINE_W'(busy), LINE_W'(1));
    rst_n = 1'b0;
    #1;
    check("rw_rst_busy", LINE_W'(busy), LINE_W'(0));
    check("rw_rst_vld", LINE_W'(rd_req_vld), LINE_W'(0));
    check("rw_rst_addr", LINE_W'(rd_req_addr), LINE_W'(0));
    check("rw_rst_rdn", rdn_weight_data, '0);
    check("rw_rst_dnn", dnn_weight_data, '0);
    tick();
    rst_n = 1'b1;
    rd_rsp_vld = 1'b1; rd_rsp_data = mk_line(64'h77);
    tick();
    rd_rsp_vld = 1'b0;
    tick();
    check("late_ready", LINE_W'(weight_mem_ready), LINE_W'(0));
    check("late_busy", LINE_W'(busy), LINE_W'(0));
    check("late_rdn", rdn_weight_data, '0);
    rdn_mem_req = 1'b0; dnn_mem_req = 1'b0;
    tick();

`ifdef WMS_PERF_CNT_EN
    // seven waiting cycles: IDLE, ISSUE, five WAIT cycles
    do_start(32'h500, 16'd1, 32'h0, 16'd0);
    check("perf_clear", LINE_W'(perf_rdn_wait), LINE_W'(0));
    rdn_mem_req = 1'b1;
    fetch("perf", 32'h500, 1'b0, 0, 5, mk_line(64'h99));
    tick();
    rdn_mem_req = 1'b0;
    check("perf_rdn", LINE_W'(perf_rdn_wait), LINE_W'(7));
    check("perf_dnn", LINE_W'(perf_dnn_wait), LINE_W'(0));
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
